// File: rtl/bsk_mgr_common_param_pkg.sv
// Parameters shared by every bsk_manager block (read and write sides).
// No logic; no latency.
// No flow control.
package bsk_mgr_common_param_pkg;
    localparam int BSK_CUT_NB = 2;
endpackage

// File: rtl/bsk_mgr_cut_wr_pkg.sv
// Types and derived sizes for the cut-RAM write dispatcher.
// No logic; no latency.
// No flow control.
package bsk_mgr_cut_wr_pkg;
    import bsk_mgr_common_param_pkg::*;

    localparam int SLOT_NB       = 8;
    localparam int SLOT_DEPTH    = 16;
    localparam int DATA_W        = 256;

    localparam int SLOT_W        = (SLOT_NB > 1) ? $clog2(SLOT_NB) : 1;
    localparam int ROW_W         = (SLOT_DEPTH > 1) ? $clog2(SLOT_DEPTH) : 1;
    localparam int CUT_W         = (BSK_CUT_NB > 1) ? $clog2(BSK_CUT_NB) : 1;
    localparam int ADD_W         = $clog2(SLOT_NB * SLOT_DEPTH);
    localparam int WORD_PER_SLOT = BSK_CUT_NB * SLOT_DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } wr_state_e;

    // Each slot owns a contiguous block of SLOT_DEPTH rows in every cut.
    function automatic logic [ADD_W-1:0] row_addr(input logic [SLOT_W-1:0] slot,
                                                  input logic [ROW_W-1:0]  row);
        return ADD_W'(int'(slot) * SLOT_DEPTH + int'(row));
    endfunction
endpackage

// File: rtl/bsk_mgr_cut_wr_cnt.sv
// Two-level wrap counter: cut index (inner) and row (outer), with last-word flag.
// Counts on the clock edge after inc; last is combinational on the current count.
// No flow control; clr has priority over inc.
module bsk_mgr_cut_wr_cnt
    import bsk_mgr_common_param_pkg::*;
    import bsk_mgr_cut_wr_pkg::*;
(
    input  logic             clk,
    input  logic             s_rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CUT_W-1:0] cut_idx,
    output logic [ROW_W-1:0] row,
    output logic             last
);
    localparam logic [CUT_W-1:0] CUT_LAST = CUT_W'(BSK_CUT_NB - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SLOT_DEPTH - 1);

    logic cut_wrap;
    logic row_wrap;

    assign cut_wrap = (cut_idx == CUT_LAST);
    assign row_wrap = (row == ROW_LAST);
    assign last     = cut_wrap && row_wrap;

    always_ff @(posedge clk) begin
        if (s_rst || clr) begin
            cut_idx <= '0;
            row     <= '0;
        end else if (inc) begin
            if (cut_wrap) begin
                cut_idx <= '0;
                row     <= row_wrap ? '0 : row + 1'b1;
            end else begin
                cut_idx <= cut_idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/bsk_mgr_cut_wr_dispatch.sv
// Loads one BSK slot into the cut RAMs, dealing words round-robin over the cuts.
// Write ports registered, one cycle after word accept; done coincides with the last write.
// cmd_rdy only in IDLE for unlocked slots; in_rdy held high for the whole LOAD phase.
module bsk_mgr_cut_wr_dispatch
    import bsk_mgr_common_param_pkg::*;
    import bsk_mgr_cut_wr_pkg::*;
(
    input  logic                        clk,
    input  logic                        s_rst,
    input  logic                        cmd_vld,
    output logic                        cmd_rdy,
    input  logic [SLOT_W-1:0]           cmd_slot,
    input  logic                        in_vld,
    output logic                        in_rdy,
    input  logic [DATA_W-1:0]           in_data,
    output logic [BSK_CUT_NB-1:0]       wr_en,
    output logic [BSK_CUT_NB*ADD_W-1:0] wr_add,
    output logic [DATA_W-1:0]           wr_data,
    input  logic [SLOT_NB-1:0]          slot_lock,
    output logic [SLOT_NB-1:0]          slot_avail,
    output logic                        done,
    output logic [SLOT_W-1:0]           done_slot,
    output logic                        err_lock
);
    wr_state_e                        state;
    logic [SLOT_W-1:0]                cur_slot;
    logic [BSK_CUT_NB-1:0][ADD_W-1:0] wr_add_q;
    logic [CUT_W-1:0]                 cut_idx;
    logic [ROW_W-1:0]                 row;
    logic                             cnt_last;
    logic                             cmd_acc;
    logic                             word_acc;

    // Held low during reset so every output reads zero while s_rst is asserted.
    assign cmd_rdy  = !s_rst && (state == ST_IDLE) && !slot_lock[cmd_slot];
    assign in_rdy   = (state == ST_LOAD);
    assign cmd_acc  = cmd_vld && cmd_rdy;
    assign word_acc = in_vld && in_rdy;
    assign wr_add   = wr_add_q;

    bsk_mgr_cut_wr_cnt u_cnt (
        .clk     (clk),
        .s_rst   (s_rst),
        .clr     (cmd_acc),
        .inc     (word_acc),
        .cut_idx (cut_idx),
        .row     (row),
        .last    (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state      <= ST_IDLE;
            cur_slot   <= '0;
            wr_en      <= '0;
            wr_add_q   <= '0;
            wr_data    <= '0;
            slot_avail <= '0;
            done       <= 1'b0;
            done_slot  <= '0;
            err_lock   <= 1'b0;
        end else begin
            wr_en <= '0;
            done  <= 1'b0;

            if (word_acc) begin
                wr_en             <= BSK_CUT_NB'(1) << cut_idx;
                wr_add_q[cut_idx] <= row_addr(cur_slot, row);
                wr_data           <= in_data;
            end

            if ((state == ST_LOAD) && slot_lock[cur_slot]) begin
                err_lock <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_acc) begin
                        cur_slot             <= cmd_slot;
                        slot_avail[cmd_slot] <= 1'b0;
                        state                <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (word_acc && cnt_last) begin
                        done      <= 1'b1;
                        done_slot <= cur_slot;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    slot_avail[cur_slot] <= 1'b1;
                    state                <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bsk_mgr_cut_wr_dispatch.sv
// Randomized bench for the cut-RAM write dispatcher against a slot/word-index model.
module tb_bsk_mgr_cut_wr_dispatch;
    import bsk_mgr_common_param_pkg::*;
    import bsk_mgr_cut_wr_pkg::*;

    logic                        clk = 1'b0;
    logic                        s_rst;
    logic                        cmd_vld;
    logic                        cmd_rdy;
    logic [SLOT_W-1:0]           cmd_slot;
    logic                        in_vld;
    logic                        in_rdy;
    logic [DATA_W-1:0]           in_data;
    logic [BSK_CUT_NB-1:0]       wr_en;
    logic [BSK_CUT_NB*ADD_W-1:0] wr_add;
    logic [DATA_W-1:0]           wr_data;
    logic [SLOT_NB-1:0]          slot_lock;
    logic [SLOT_NB-1:0]          slot_avail;
    logic                        done;
    logic [SLOT_W-1:0]           done_slot;
    logic                        err_lock;

    int checks   = 0;
    int failures = 0;

    logic [SLOT_NB-1:0] m_avail;
    logic               m_err;
    logic [DATA_W-1:0]  words [WORD_PER_SLOT];

    always #5 clk = ~clk;

    bsk_mgr_cut_wr_dispatch dut (
        .clk        (clk),
        .s_rst      (s_rst),
        .cmd_vld    (cmd_vld),
        .cmd_rdy    (cmd_rdy),
        .cmd_slot   (cmd_slot),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_data    (in_data),
        .wr_en      (wr_en),
        .wr_add     (wr_add),
        .wr_data    (wr_data),
        .slot_lock  (slot_lock),
        .slot_avail (slot_avail),
        .done       (done),
        .done_slot  (done_slot),
        .err_lock   (err_lock)
    );

    // Full slot load: command handshake, word stream, per-cycle write-port and done checks.
    // Returns at #1 after the edge that enters the IDLE cycle following DONE.
    task automatic run_load(input int slot, input bit bubbles, input int lock_at, input bit idx_data);
        int k      = 0;
        int pend_k = -1;
        int writes = 0;
        bit acc    = 0;
        bit fin    = 0;
        bit first  = 1;
        logic [BSK_CUT_NB-1:0] exp_en;
        logic [ADD_W-1:0]      exp_add;
        for (int i = 0; i < WORD_PER_SLOT; i++)
            words[i] = idx_data ? DATA_W'(i) : {8{$urandom()}};

        cmd_vld  = 1'b1;
        cmd_slot = SLOT_W'(slot);
        for (int cyc = 0; cyc < 50 && !acc; cyc++) begin
            @(negedge clk);
            checks++;
            if (cmd_rdy !== !slot_lock[slot]) begin
                failures++;
                $display("FAIL cmd_rdy slot=%0d: got %b want %b", slot, cmd_rdy, !slot_lock[slot]);
            end
            checks++;
            if (slot_avail !== m_avail) begin
                failures++;
                $display("FAIL avail_idle slot=%0d: got %h want %h", slot, slot_avail, m_avail);
            end
            acc = cmd_rdy;
            @(posedge clk); #1;
        end
        cmd_vld = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL cmd_accept_timeout slot=%0d: got no accept want accept", slot);
            return;
        end
        m_avail[slot] = 1'b0;

        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            in_vld  = (k < WORD_PER_SLOT) && (!bubbles || ($urandom_range(1, 0) == 1));
            in_data = in_vld ? words[k] : {8{$urandom()}};
            if (k == lock_at) slot_lock[slot] = 1'b1;
            @(negedge clk);
            if (first) begin
                checks++;
                if (slot_avail !== m_avail) begin
                    failures++;
                    $display("FAIL avail_after_accept slot=%0d: got %h want %h", slot, slot_avail, m_avail);
                end
                first = 0;
            end
            checks++;
            if (in_rdy !== (k < WORD_PER_SLOT)) begin
                failures++;
                $display("FAIL in_rdy word=%0d: got %b want %b", k, in_rdy, (k < WORD_PER_SLOT));
            end
            checks++;
            if (cmd_rdy !== 1'b0) begin
                failures++;
                $display("FAIL cmd_rdy_busy word=%0d: got %b want 0", k, cmd_rdy);
            end
            exp_en = (pend_k >= 0) ? BSK_CUT_NB'(1) << (pend_k % BSK_CUT_NB) : '0;
            checks++;
            if (wr_en !== exp_en) begin
                failures++;
                $display("FAIL wr_en word=%0d: got %b want %b", pend_k, wr_en, exp_en);
            end
            if (pend_k >= 0) begin
                writes++;
                exp_add = ADD_W'(slot * SLOT_DEPTH + pend_k / BSK_CUT_NB);
                checks++;
                if (wr_add[(pend_k % BSK_CUT_NB) * ADD_W +: ADD_W] !== exp_add) begin
                    failures++;
                    $display("FAIL wr_add word=%0d: got %0d want %0d", pend_k,
                             wr_add[(pend_k % BSK_CUT_NB) * ADD_W +: ADD_W], exp_add);
                end
                checks++;
                if (wr_data !== words[pend_k]) begin
                    failures++;
                    $display("FAIL wr_data word=%0d: got %h want %h", pend_k, wr_data, words[pend_k]);
                end
            end
            checks++;
            if (done !== (pend_k == WORD_PER_SLOT - 1)) begin
                failures++;
                $display("FAIL done word=%0d: got %b want %b", pend_k, done, (pend_k == WORD_PER_SLOT - 1));
            end
            if (pend_k == WORD_PER_SLOT - 1) begin
                checks++;
                if (done_slot !== SLOT_W'(slot)) begin
                    failures++;
                    $display("FAIL done_slot: got %0d want %0d", done_slot, slot);
                end
                fin = 1;
            end
            checks++;
            if (err_lock !== m_err) begin
                failures++;
                $display("FAIL err_lock word=%0d: got %b want %b", k, err_lock, m_err);
            end
            if (k < WORD_PER_SLOT && slot_lock[slot]) m_err = 1'b1;
            pend_k = (in_vld && k < WORD_PER_SLOT) ? k : -1;
            if (pend_k >= 0) k++;
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL load_timeout slot=%0d: got %0d words want %0d", slot, k, WORD_PER_SLOT);
        end
        m_avail[slot] = 1'b1;
        checks++;
        if (writes != WORD_PER_SLOT) begin
            failures++;
            $display("FAIL write_count slot=%0d: got %0d want %0d", slot, writes, WORD_PER_SLOT);
        end
    endtask

    task automatic test_reset();
        s_rst = 1'b1; cmd_vld = 1'b0; cmd_slot = '0; in_vld = 1'b0;
        in_data = '0; slot_lock = '0; m_avail = '0; m_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (cmd_rdy !== 1'b0 || in_rdy !== 1'b0 || done !== 1'b0 || err_lock !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got rdy=%b/%b done=%b err=%b want 0", cmd_rdy, in_rdy, done, err_lock);
        end
        checks++;
        if (wr_en !== '0 || wr_add !== '0 || wr_data !== '0) begin
            failures++;
            $display("FAIL reset_wr: got en=%b add=%h data=%h want 0", wr_en, wr_add, wr_data);
        end
        checks++;
        if (slot_avail !== '0 || done_slot !== '0) begin
            failures++;
            $display("FAIL reset_slot: got avail=%h done_slot=%0d want 0", slot_avail, done_slot);
        end
        @(posedge clk); #1;
        s_rst = 1'b0;
    endtask

    task automatic test_basic_load();
        run_load(3, 0, -1, 1);
        @(negedge clk);
        checks++;
        if (slot_avail !== 8'h08) begin
            failures++;
            $display("FAIL basic_avail: got %h want 08", slot_avail);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bubbles();
        run_load(3, 1, -1, 0);
    endtask

    task automatic test_lock_block();
        slot_lock[5] = 1'b1;
        cmd_vld      = 1'b1;
        cmd_slot     = SLOT_W'(5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_rdy !== 1'b0) begin
                failures++;
                $display("FAIL lock_block cycle=%0d: got cmd_rdy %b want 0", i, cmd_rdy);
            end
            @(posedge clk); #1;
        end
        slot_lock[5] = 1'b0;
        run_load(5, 1, -1, 0);
    endtask

    task automatic test_reload();
        run_load(0, 0, -1, 0);
        run_load(0, 1, -1, 0);
        @(negedge clk);
        checks++;
        if (slot_avail[0] !== 1'b1 || slot_avail !== m_avail) begin
            failures++;
            $display("FAIL reload_avail: got %h want %h", slot_avail, m_avail);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        slot_lock[4] = 1'b1;
        run_load(2, 0, -1, 0);
        run_load(1, 1, -1, 0);
        slot_lock[4] = 1'b0;
    endtask

    task automatic test_lock_during_load();
        run_load(6, 1, 12, 0);
        slot_lock[6] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (err_lock !== 1'b1 || slot_avail !== m_avail) begin
            failures++;
            $display("FAIL err_sticky: got err=%b avail=%h want 1 %h", err_lock, slot_avail, m_avail);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load();
        int k = 0;
        cmd_vld  = 1'b1;
        cmd_slot = SLOT_W'(2);
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        for (int cyc = 0; cyc < 40 && k < 10; cyc++) begin
            in_vld  = 1'b1;
            in_data = {8{$urandom()}};
            @(negedge clk);
            if (in_rdy) k++;
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        s_rst  = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cmd_rdy, in_rdy, wr_en, wr_add, wr_data, slot_avail, done, done_slot, err_lock} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got rdy=%b/%b en=%b avail=%h done=%b err=%b want 0",
                     cmd_rdy, in_rdy, wr_en, slot_avail, done, err_lock);
        end
        @(posedge clk); #1;
        s_rst   = 1'b0;
        m_avail = '0;
        m_err   = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || wr_en !== '0 || slot_avail !== '0) begin
            failures++;
            $display("FAIL post_reset: got done=%b en=%b avail=%h want 0", done, wr_en, slot_avail);
        end
        @(posedge clk); #1;
        run_load(7, 0, -1, 0);
        @(negedge clk);
        checks++;
        if (slot_avail !== 8'h80) begin
            failures++;
            $display("FAIL reload_after_reset_avail: got %h want 80", slot_avail);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bubbles();
        test_lock_block();
        test_reload();
        test_back_to_back();
        test_lock_during_load();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
